// File: rtl/mesh_adapter_shared_pe_pkg.sv
// Mesh field layout, widths and request/response records shared by the shared-PE mesh adapter.
package mesh_adapter_shared_pe_pkg;

    localparam int MESH_W                      = 64;
    localparam int ADDR_WIDTH                  = 16;
    localparam int LAZY_LEN_LOG2               = 3;
    localparam int NUM_JOB_PE_LOG2             = 4;
    localparam int MESH_X_SIZE_LOG2            = 2;
    localparam int MESH_Y_SIZE_LOG2            = 3;
    localparam int MATCH_LEN_WIDTH             = 8;
    localparam int IN_MESH_MATCH_PE_ADDR_WIDTH = 10;

    // Request flit field offsets, identical on the job-side adapter.
    localparam int MESH_REQ_JOBIDX_LSB = 0;
    localparam int MESH_REQ_TAG_LSB    = MESH_REQ_JOBIDX_LSB + NUM_JOB_PE_LOG2;
    localparam int MESH_REQ_HIST_LSB   = MESH_REQ_TAG_LSB + LAZY_LEN_LOG2;
    localparam int MESH_REQ_HEAD_LSB   = MESH_REQ_HIST_LSB + ADDR_WIDTH;
    localparam int MESH_REQ_W          = MESH_REQ_HEAD_LSB + ADDR_WIDTH;

    typedef logic [ADDR_WIDTH-1:0]      addr_t;
    typedef logic [NUM_JOB_PE_LOG2-1:0] job_idx_t;
    typedef logic [LAZY_LEN_LOG2-1:0]   tag_t;
    typedef logic [MATCH_LEN_WIDTH-1:0] match_len_t;

    typedef struct packed {
        addr_t    head_addr;
        addr_t    history_addr;
        tag_t     tag;
        job_idx_t job_idx;
    } req_t;

    typedef struct packed {
        job_idx_t job_idx;
        tag_t     tag;
    } id_t;

    typedef struct packed {
        job_idx_t   job_idx;
        tag_t       tag;
        match_len_t match_len;
    } resp_t;

    function automatic req_t decode_req(input logic [MESH_REQ_W-1:0] flit);
        req_t r;
        r.job_idx      = flit[MESH_REQ_JOBIDX_LSB +: NUM_JOB_PE_LOG2];
        r.tag          = flit[MESH_REQ_TAG_LSB +: LAZY_LEN_LOG2];
        r.history_addr = flit[MESH_REQ_HIST_LSB +: ADDR_WIDTH];
        r.head_addr    = flit[MESH_REQ_HEAD_LSB +: ADDR_WIDTH];
        return r;
    endfunction

endpackage

// File: rtl/mesh_adapter_shared_pe_if.sv
// Mesh and shared-PE handshake bundle; master is the adapter's view, slave the surroundings'.
interface mesh_adapter_shared_pe_if;
    import mesh_adapter_shared_pe_pkg::*;

    logic                        from_mesh_valid;
    logic                        from_mesh_ready;
    logic [MESH_W-1:0]           from_mesh_payload;
    logic                        match_req_valid;
    logic                        match_req_ready;
    addr_t                       match_req_head_addr;
    addr_t                       match_req_history_addr;
    logic                        match_resp_valid;
    logic                        match_resp_ready;
    match_len_t                  match_resp_match_len;
    logic                        to_mesh_valid;
    logic                        to_mesh_ready;
    logic [MESH_X_SIZE_LOG2-1:0] to_mesh_x_dst;
    logic [MESH_Y_SIZE_LOG2-1:0] to_mesh_y_dst;
    logic [MESH_W-1:0]           to_mesh_payload;

    modport master (
        input  from_mesh_valid, from_mesh_payload, match_req_ready,
               match_resp_valid, match_resp_match_len, to_mesh_ready,
        output from_mesh_ready, match_req_valid, match_req_head_addr,
               match_req_history_addr, match_resp_ready, to_mesh_valid,
               to_mesh_x_dst, to_mesh_y_dst, to_mesh_payload
    );

    modport slave (
        output from_mesh_valid, from_mesh_payload, match_req_ready,
               match_resp_valid, match_resp_match_len, to_mesh_ready,
        input  from_mesh_ready, match_req_valid, match_req_head_addr,
               match_req_history_addr, match_resp_ready, to_mesh_valid,
               to_mesh_x_dst, to_mesh_y_dst, to_mesh_payload
    );
endinterface

// File: rtl/mesh_adapter_shared_pe_sync_id_fifo.sv
// Synchronous FIFO with registered storage and full/empty/count flags.
// Latency: a push in cycle N is visible at pop_dat in cycle N+1.
// Backpressure: caller gates push on !full (or a same-cycle pop) and pop on !empty.
module sync_id_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_vld,
    output logic [WIDTH-1:0]       pop_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_vld) begin
                mem[wr_ptr[AW-1:0]] <= push_dat;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (pop_vld) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Pointers carry one extra bit so full and empty differ only in that bit.
    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == (AW+1)'(DEPTH));
    assign pop_dat = mem[rd_ptr[AW-1:0]];
endmodule

// File: rtl/mesh_adapter_shared_pe.sv
// Mesh endpoint for one shared match PE: decodes requests, tracks origin, routes results back.
// Latency: request accept N -> match_req_valid N+1; result accept N -> to_mesh_valid N+1.
// Backpressure: all readies come from registered occupancy, never from a same-cycle ready.
module mesh_adapter_shared_pe
    import mesh_adapter_shared_pe_pkg::*;
#(
    parameter int SHARED_PE_IDX     = 0,
    parameter int OUTSTANDING_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    mesh_adapter_shared_pe_if.master bus,
    output logic                     misroute_err
);
    localparam int ID_CW = $clog2(OUTSTANDING_DEPTH) + 1;
    localparam int OCW   = ID_CW + 1;
    localparam job_idx_t PE_IDX = NUM_JOB_PE_LOG2'(SHARED_PE_IDX);

    req_t             req_in;
    req_t             req_q;
    logic             req_push;
    logic             req_full;
    logic             req_empty;
    logic [1:0]       req_cnt;
    id_t              id_q;
    logic             id_push;
    logic             id_pop;
    logic             id_empty;
    logic             id_full_unused;
    logic [ID_CW-1:0] id_cnt;
    resp_t            resp_in;
    resp_t            resp_q;
    logic             resp_pop;
    logic             resp_full;
    logic             resp_empty;
    logic [1:0]       resp_cnt_unused;
    logic             payload_hi_unused;

    assign req_in            = decode_req(bus.from_mesh_payload[MESH_REQ_W-1:0]);
    assign payload_hi_unused = ^bus.from_mesh_payload[MESH_W-1:MESH_REQ_W];

    // Occupancy counts both the request stage and requests already inside the PE.
    assign bus.from_mesh_ready = !rst && !req_full &&
                                 ((OCW'(req_cnt) + OCW'(id_cnt)) < OCW'(OUTSTANDING_DEPTH));
    assign req_push = bus.from_mesh_valid && bus.from_mesh_ready;

    sync_id_fifo #(.WIDTH($bits(req_t)), .DEPTH(2)) u_req_buf (
        .clk      (clk),
        .rst      (rst),
        .push_vld (req_push),
        .push_dat (req_in),
        .pop_vld  (id_push),
        .pop_dat  (req_q),
        .full     (req_full),
        .empty    (req_empty),
        .count    (req_cnt)
    );

    assign bus.match_req_valid        = !req_empty;
    assign bus.match_req_head_addr    = req_q.head_addr;
    assign bus.match_req_history_addr = req_q.history_addr;
    assign id_push = bus.match_req_valid && bus.match_req_ready;

    sync_id_fifo #(.WIDTH($bits(id_t)), .DEPTH(OUTSTANDING_DEPTH)) u_id_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (id_push),
        .push_dat ({req_q.job_idx, req_q.tag}),
        .pop_vld  (id_pop),
        .pop_dat  (id_q),
        .full     (id_full_unused),
        .empty    (id_empty),
        .count    (id_cnt)
    );

    // PE results arrive in request order, so the FIFO head is always the owner.
    assign bus.match_resp_ready = !rst && !resp_full && !id_empty;
    assign id_pop  = bus.match_resp_valid && bus.match_resp_ready;
    assign resp_in = '{job_idx: id_q.job_idx, tag: id_q.tag, match_len: bus.match_resp_match_len};

    sync_id_fifo #(.WIDTH($bits(resp_t)), .DEPTH(2)) u_resp_buf (
        .clk      (clk),
        .rst      (rst),
        .push_vld (id_pop),
        .push_dat (resp_in),
        .pop_vld  (resp_pop),
        .pop_dat  (resp_q),
        .full     (resp_full),
        .empty    (resp_empty),
        .count    (resp_cnt_unused)
    );

    // Job PEs sit on even mesh rows; the row index is the upper job_idx bits shifted up.
    assign bus.to_mesh_valid   = !resp_empty;
    assign bus.to_mesh_x_dst   = resp_q.job_idx[MESH_X_SIZE_LOG2-1:0];
    assign bus.to_mesh_y_dst   = {resp_q.job_idx[NUM_JOB_PE_LOG2-1:MESH_X_SIZE_LOG2], 1'b0};
    assign bus.to_mesh_payload = MESH_W'({resp_q.match_len, resp_q.tag});
    assign resp_pop = bus.to_mesh_valid && bus.to_mesh_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            misroute_err <= 1'b0;
        end else if ((req_push &&
                      (req_in.history_addr[IN_MESH_MATCH_PE_ADDR_WIDTH +: NUM_JOB_PE_LOG2] != PE_IDX)) ||
                     (bus.match_resp_valid && id_empty)) begin
            misroute_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mesh_adapter_shared_pe.sv
// Scoreboard bench: expectations queued at send time, checked as each handshake completes.
module tb_mesh_adapter_shared_pe;
    import mesh_adapter_shared_pe_pkg::*;

    typedef struct {
        logic [15:0] head;
        logic [15:0] hist;
        logic [7:0]  len;
    } mreq_exp_t;

    typedef struct {
        logic [1:0]  x;
        logic [2:0]  y;
        logic [63:0] pay;
    } out_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic misroute_err;

    mesh_adapter_shared_pe_if bus ();

    mesh_adapter_shared_pe #(.SHARED_PE_IDX(0), .OUTSTANDING_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .misroute_err (misroute_err)
    );

    always #5 clk = ~clk;

    logic [MESH_W-1:0] flit_q[$];
    mreq_exp_t         mreq_q[$];
    logic [7:0]        pe_q[$];
    out_exp_t          out_q[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;
    int last_acc_cyc, last_mreq_cyc, last_mresp_cyc, last_out_cyc, first_pop_cyc;
    logic [63:0] last_out_pay;
    logic [1:0]  last_out_x;
    logic [2:0]  last_out_y;
    bit pe_ready_en, resp_en, sink_en, resp_force;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic send(input int job, input int tag, input int head, input int hist, input int len);
        logic [MESH_W-1:0] f;
        mreq_exp_t m;
        out_exp_t  o;
        f = '0;
        f[MESH_REQ_JOBIDX_LSB +: NUM_JOB_PE_LOG2] = NUM_JOB_PE_LOG2'(job);
        f[MESH_REQ_TAG_LSB +: LAZY_LEN_LOG2]      = LAZY_LEN_LOG2'(tag);
        f[MESH_REQ_HIST_LSB +: ADDR_WIDTH]        = ADDR_WIDTH'(hist);
        f[MESH_REQ_HEAD_LSB +: ADDR_WIDTH]        = ADDR_WIDTH'(head);
        f[MESH_W-1:MESH_REQ_W]                    = (MESH_W-MESH_REQ_W)'($urandom);
        flit_q.push_back(f);
        m.head = 16'(head);
        m.hist = 16'(hist);
        m.len  = 8'(len);
        mreq_q.push_back(m);
        o.x   = 2'(job % 4);
        o.y   = 3'((job / 4) * 2);
        o.pay = 64'(len) * 64'd8 + 64'(tag % 8);
        out_q.push_back(o);
    endtask

    task automatic cyc();
        logic [MESH_W-1:0] f;
        mreq_exp_t m;
        out_exp_t  o;
        logic [7:0] l;
        @(negedge clk);
        cyc_n++;
        bus.from_mesh_valid      = (flit_q.size() > 0);
        bus.from_mesh_payload    = (flit_q.size() > 0) ? flit_q[0] : '0;
        bus.match_req_ready      = pe_ready_en;
        bus.match_resp_valid     = resp_force || (resp_en && pe_q.size() > 0);
        bus.match_resp_match_len = (pe_q.size() > 0) ? pe_q[0] : '0;
        bus.to_mesh_ready        = sink_en;
        #1;
        if (bus.from_mesh_valid && bus.from_mesh_ready) begin
            f = flit_q.pop_front();
            last_acc_cyc = cyc_n;
        end
        if (bus.match_resp_valid && bus.match_resp_ready) begin
            last_mresp_cyc = cyc_n;
            if (first_pop_cyc < 0) first_pop_cyc = cyc_n;
            if (pe_q.size() > 0) l = pe_q.pop_front();
            else check_eq("mresp_spurious", bus.match_resp_ready, 0);
        end
        if (bus.match_req_valid && bus.match_req_ready) begin
            last_mreq_cyc = cyc_n;
            if (mreq_q.size() == 0) begin
                check_eq("mreq_spurious", bus.match_req_valid, 0);
            end else begin
                m = mreq_q.pop_front();
                check_eq("mreq_head", bus.match_req_head_addr, m.head);
                check_eq("mreq_hist", bus.match_req_history_addr, m.hist);
                pe_q.push_back(m.len);
            end
        end
        if (bus.to_mesh_valid && bus.to_mesh_ready) begin
            last_out_cyc = cyc_n;
            last_out_pay = bus.to_mesh_payload;
            last_out_x   = bus.to_mesh_x_dst;
            last_out_y   = bus.to_mesh_y_dst;
            if (out_q.size() == 0) begin
                check_eq("out_spurious", bus.to_mesh_valid, 0);
            end else begin
                o = out_q.pop_front();
                check_eq("out_x", bus.to_mesh_x_dst, o.x);
                check_eq("out_y", bus.to_mesh_y_dst, o.y);
                check_eq("out_payload", bus.to_mesh_payload, o.pay);
            end
        end
    endtask

    task automatic drain(input string tag, input int budget, output int used);
        used = 0;
        while ((flit_q.size() + mreq_q.size() + pe_q.size() + out_q.size()) != 0 && used < budget) begin
            cyc();
            used++;
        end
        check_eq({tag, "_drain"}, flit_q.size() + mreq_q.size() + pe_q.size() + out_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.from_mesh_valid      = 1'b0;
        bus.from_mesh_payload    = '0;
        bus.match_req_ready      = 1'b0;
        bus.match_resp_valid     = 1'b0;
        bus.match_resp_match_len = '0;
        bus.to_mesh_ready        = 1'b0;
        flit_q.delete();
        mreq_q.delete();
        pe_q.delete();
        out_q.delete();
        pe_ready_en = 1'b1;
        resp_en     = 1'b1;
        sink_en     = 1'b1;
        resp_force  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_from_mesh_ready", bus.from_mesh_ready, 0);
        check_eq("rst_match_req_valid", bus.match_req_valid, 0);
        check_eq("rst_to_mesh_valid", bus.to_mesh_valid, 0);
        check_eq("rst_match_resp_ready", bus.match_resp_ready, 0);
        check_eq("rst_to_mesh_payload", bus.to_mesh_payload, 0);
        check_eq("rst_misroute_err", misroute_err, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("post_rst_from_mesh_ready", bus.from_mesh_ready, 1);
        check_eq("post_rst_match_resp_ready", bus.match_resp_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int used;
        first_pop_cyc = -1;
        do_reset();

        // Single request: latencies and exact response encoding.
        send(5, 2, 'h120, 'h0040, 17);
        drain("t1", 20, used);
        check_eq("t1_req_latency", last_mreq_cyc - last_acc_cyc, 1);
        check_eq("t1_resp_latency", last_out_cyc - last_mresp_cyc, 1);
        check_eq("t1_x", last_out_x, 1);
        check_eq("t1_y", last_out_y, 2);
        check_eq("t1_payload", last_out_pay, 64'd138);

        // Outstanding limit: PE accepts but withholds results.
        resp_en = 1'b0;
        for (int i = 0; i < 5; i++) send(i + 1, i, 'h200 + i, 'h0100 + i, 40 + i);
        repeat (8) cyc();
        check_eq("t2_flits_held", flit_q.size(), 1);
        check_eq("t2_from_mesh_ready", bus.from_mesh_ready, 0);
        first_pop_cyc = -1;
        resp_en = 1'b1;
        used = 0;
        while (flit_q.size() != 0 && used < 20) begin
            cyc();
            used++;
        end
        check_eq("t2_refill_cycle", last_acc_cyc, first_pop_cyc + 1);
        drain("t2", 40, used);

        // Streaming: one request per cycle end to end.
        for (int i = 0; i < 20; i++) send(i % 16, i % 8, 'h1000 + i * 16, i * 3, 20 + i);
        drain("t3", 100, used);
        check_eq("t3_cycles", used, 23);

        // Mesh stall: response buffer fills, then PE backpressure.
        sink_en = 1'b0;
        for (int i = 0; i < 4; i++) send(9 + i, 7 - i, 'h3000 + i, 'h0200 + i, 100 + i);
        repeat (10) cyc();
        check_eq("t4_to_mesh_valid", bus.to_mesh_valid, 1);
        check_eq("t4_match_resp_ready", bus.match_resp_ready, 0);
        check_eq("t4_payload_head", bus.to_mesh_payload, out_q[0].pay);
        repeat (3) cyc();
        check_eq("t4_payload_stable", bus.to_mesh_payload, out_q[0].pay);
        check_eq("t4_out_pending", out_q.size(), 4);
        sink_en = 1'b1;
        drain("t4", 40, used);

        // Misrouted request is forwarded and latches the error.
        send(6, 1, 'h0300, 'h0440, 9);
        drain("t5", 20, used);
        check_eq("t5_misroute_set", misroute_err, 1);
        repeat (3) cyc();
        check_eq("t5_misroute_sticky", misroute_err, 1);
        do_reset();

        // Result with no recorded owner: refused and flagged.
        resp_force = 1'b1;
        cyc();
        check_eq("t5_orphan_resp_ready", bus.match_resp_ready, 0);
        resp_force = 1'b0;
        cyc();
        check_eq("t5_orphan_misroute", misroute_err, 1);
        do_reset();

        // Reset mid-operation with three outstanding and one queued response.
        sink_en = 1'b0;
        resp_en = 1'b0;
        for (int i = 0; i < 4; i++) send(i + 4, i + 1, 'h4000 + i, 'h0300 + i, 60 + i);
        repeat (6) cyc();
        resp_en = 1'b1;
        cyc();
        resp_en = 1'b0;
        cyc();
        check_eq("t6_queued_resp", bus.to_mesh_valid, 1);
        check_eq("t6_outstanding_ready", bus.from_mesh_ready, 1);
        do_reset();
        send(13, 4, 'h0abc, 'h0123, 55);
        drain("t6", 20, used);
        check_eq("t6_fresh_payload", last_out_pay, 64'd444);
        check_eq("t6_fresh_y", last_out_y, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mesh_adapter_shared_pe.md
Name: mesh_adapter_shared_pe

Overview:
- Mesh endpoint in front of one shared match PE; the counterpart of the job-PE-side mesh adapter.
- Accepts match-request flits from the mesh, decodes them and issues them to the shared match PE.
- Records the originating job PE and tag of each request, pairs each in-order result with its record, and routes a response flit back to that job PE's mesh node.

Parameters:
- SHARED_PE_IDX, 0, index of this shared PE; must equal history_addr[IN_MESH_MATCH_PE_ADDR_WIDTH +: NUM_JOB_PE_LOG2].
- OUTSTANDING_DEPTH, 4, maximum requests in flight inside the shared PE; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- from_mesh_valid  in  1  request flit valid
- from_mesh_ready  out  1  request flit accepted
- from_mesh_payload  in  MESH_W  request flit
- match_req_valid  out  1  request to shared PE
- match_req_ready  in  1  shared PE accepts
- match_req_head_addr  out  ADDR_WIDTH  head address
- match_req_history_addr  out  ADDR_WIDTH  history address
- match_resp_valid  in  1  shared PE result valid (in request order)
- match_resp_ready  out  1  result accepted
- match_resp_match_len  in  MATCH_LEN_WIDTH  result length
- to_mesh_valid  out  1  response flit valid
- to_mesh_ready  in  1  mesh accepts
- to_mesh_x_dst  out  MESH_X_SIZE_LOG2  destination x
- to_mesh_y_dst  out  MESH_Y_SIZE_LOG2  destination y
- to_mesh_payload  out  MESH_W  response flit
- misroute_err  out  1  sticky protocol error

Behaviour:
- Request payload layout, LSB upward: job_idx[NUM_JOB_PE_LOG2], tag[LAZY_LEN_LOG2], history_addr[ADDR_WIDTH], head_addr[ADDR_WIDTH]. Upper bits are ignored.
- Request path:
  - Flit enters a 2-entry pingpong buffer; acceptance cycle N gives match_req_valid at N+1.
  - Full throughput: one request per cycle.
  - from_mesh_ready = buffer not full AND outstanding count < OUTSTANDING_DEPTH. The count covers entries in the buffer plus entries in the ID FIFO.
- ID FIFO:
  - Depth OUTSTANDING_DEPTH, entries {job_idx, tag}.
  - Push on match_req_valid && match_req_ready; pop on match_resp_valid && match_resp_ready.
  - Push and pop in the same cycle while full: both occur, count unchanged.
  - Read/write pointers are log2(DEPTH)+1 bits wide and wrap naturally.
- Response path:
  - match_resp_ready = response pingpong not full AND ID FIFO not empty.
  - Accepted in cycle N gives to_mesh_valid at N+1. Full throughput.
  - to_mesh_payload = zero-extended {match_len, tag}, with tag in the LSBs.
  - Destination from job_idx = {y_hi, x}: to_mesh_x_dst = job_idx[MESH_X_SIZE_LOG2-1:0]; to_mesh_y_dst = {job_idx[NUM_JOB_PE_LOG2-1:MESH_X_SIZE_LOG2], 1'b0}. Job PEs occupy even rows, shared PEs odd rows.
- misroute_err (sticky until rst) sets when either occurs:
  - an accepted request's history_addr PE-index field differs from SHARED_PE_IDX; the request is still forwarded;
  - match_resp_valid is asserted while the ID FIFO is empty; ready stays low, nothing is consumed.
- Valid/payload stay stable until the handshake; no combinational path ready-to-ready or valid-to-valid across the block.
- Reset values: all valids 0, from_mesh_ready 0 while rst is high (1 on the first cycle after release if there is room), match_resp_ready 0, count 0, pointers 0, misroute_err 0, payload registers 0.
- Reset mid-operation: all buffered flits and FIFO contents are discarded. In-flight shared-PE results are the caller's responsibility and are reset together.

Decomposition:
- parameters.vh supplies MESH_W, ADDR_WIDTH, LAZY_LEN_LOG2, NUM_JOB_PE_LOG2, MESH_*_SIZE_LOG2, MATCH_LEN_WIDTH, WINDOW_LOG.
- Add to parameters.vh: MESH_REQ_JOBIDX_LSB, MESH_REQ_TAG_LSB, MESH_REQ_HIST_LSB, MESH_REQ_HEAD_LSB field offsets, shared with the job-side adapter.
- One sub-module: sync_id_fifo (synchronous FIFO, full/empty/count). Pingpong stages reuse pingpong_reg with an active-low reset derived as ~rst.

Test Plan:
- Single request: head=0x120, hist in this PE's window, tag=2, job_idx=5 (MESH_X_SIZE_LOG2=2) → match_req next cycle with the same addresses. Respond match_len=17 → to_mesh x=1, y=2, payload low bits {17,2}, one cycle later.
- Burst of 4 requests, shared PE holds ready low → 5th flit sees from_mesh_ready=0 until the first response pops. Responses return in order with the correct tags/job_idx.
- Streaming with count full: request push and response pop every cycle for 20 cycles → count stays at 4, no bubbles, no loss.
- to_mesh_ready low for 6 cycles → 2 responses buffered, then match_resp_ready=0. Release → all delivered in order, payload unchanged while stalled.
- History PE-index field ≠ SHARED_PE_IDX → request forwarded, misroute_err=1 until rst. Separately, match_resp_valid with empty FIFO → misroute_err=1, match_resp_ready=0.
- rst asserted with 3 outstanding and 1 queued response → next cycle all valids 0, count 0; a fresh request afterwards completes normally.
